status_cond_unit: RTL

Program status and condition unit sitting directly downstream of the ALU. Latches the ALU's C/N/V/Z outputs into the architectural flag register when the executing instruction sets flags. Evaluates the 4-bit condition field of the next instruction against those flags and registers a single cond_true bit for the pipeline. Feeds the stored carry back to the ALU Cin input.

---
 rtl/status_pkg.sv | 29 ++
 rtl/cond_eval.sv | 41 ++++
 rtl/status_cond_unit.sv | 80 ++++++++
 3 files changed

// File: rtl/status_pkg.sv
// Shared condition-code and flag-index definitions for the status/condition unit
// and for any other block that evaluates condition fields, such as branch resolution.
package status_pkg;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational condition evaluator: decides whether a 4-bit condition
// field passes against a {N,Z,C,V} flag vector.
module cond_eval
    import status_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    // Decode the condition field against the supplied flags
    always_comb begin
        pass_o = 1'b0;
        unique case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_cond_unit.sv
// Program status and condition unit. Holds the architectural {N,Z,C,V} flags,
// registers whether the issued instruction executes, and feeds carry back to the ALU.
// Build option: define STATUS_FLAG_BYPASS_EN to forward the ALU flags being written
// this cycle into condition evaluation; otherwise a same-cycle dependency raises
// flag_hazard and the issue stage must hold the instruction.
module status_cond_unit
    import status_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_c,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       s_en,
    input  logic       stall,
    input  logic [3:0] cond,
    input  logic       cond_valid,
    output logic       cond_true,
    output logic [3:0] flags_q,
    output logic       carry_q,
    output logic       flag_hazard
);

    logic [3:0] alu_flags;
    logic [3:0] eff_flags;
    logic [3:0] flags_d;
    logic       cond_pass;
    logic       cond_true_q;
    logic       cond_true_d;

    assign alu_flags = {alu_n, alu_z, alu_c, alu_v};

`ifdef STATUS_FLAG_BYPASS_EN
    // Forward the flags being written now so dependent instructions need no stall
    assign eff_flags   = s_en ? alu_flags : flags_q;
    assign flag_hazard = 1'b0;
`else
    // AL does not read flags, so it may issue alongside a flag write
    assign eff_flags   = flags_q;
    assign flag_hazard = s_en && cond_valid && (cond != COND_AL);
`endif

    cond_eval u_cond_eval (
        .cond_i  (cond),
        .flags_i (eff_flags),
        .pass_o  (cond_pass)
    );

    // Next-state for flags and cond_true; stall freezes both
    always_comb begin
        flags_d     = flags_q;
        cond_true_d = cond_true_q;
        if (!stall) begin
            if (s_en) begin
                flags_d = alu_flags;
            end
            if (flag_hazard) begin
                cond_true_d = 1'b0;
            end else begin
                cond_true_d = cond_valid && cond_pass;
            end
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q     <= 4'b0000;
            cond_true_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            cond_true_q <= cond_true_d;
        end
    end

    assign cond_true = cond_true_q;
    assign carry_q   = flags_q[FLAG_C];

endmodule
